// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiter: state encoding,
// owner IDs and the command record latched on each grant.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 12;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic OWN_ST  = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  function automatic mem_cmd_t pack_cmd(input logic we, input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    mem_cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Bounded-starvation tracker: counts ST grants won while DMA was waiting and
// hands priority to DMA once MAX_DEFER of them have gone by.
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int MAX_DEFER = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic st_req,
  input  logic dma_req,
  input  logic grant,
  input  logic winner,
  output logic dma_priority
);

  logic [3:0] r_defer_cnt;
  logic       w_at_limit;

  assign w_at_limit   = (r_defer_cnt == 4'(MAX_DEFER));
  assign dma_priority = st_req & dma_req & w_at_limit;

  // A cycle with no DMA request means nobody is being starved, so the count restarts.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_defer_cnt <= 4'd0;
    end else if (!dma_req || (grant && winner == OWN_DMA)) begin
      r_defer_cnt <= 4'd0;
    end else if (grant && winner == OWN_ST && st_req && !w_at_limit) begin
      r_defer_cnt <= r_defer_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the pipeline load/store path (ST) and a DMA
// master: IDLE arbitrates, GRANT holds the port command, RESP pulses done.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DEFER = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_req,
  input  logic              st_we,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [DATA_W-1:0] st_rdata,
  output logic              st_done,
  output logic              st_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a requester holds req (and its command) until its done pulse and
  // drops it on the following edge; a req seen in IDLE is always a new access.
  // On the port, mem_valid is high for every GRANT cycle with a stable command,
  // and mem_ack completes the access only while mem_valid is high.

  logic [1:0]        r_state;
  logic              r_owner;
  mem_cmd_t          r_cmd;
  logic [7:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_st_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_timeout_err;

  logic     w_any_req;
  logic     w_grant;
  logic     w_winner;
  logic     w_dma_priority;
  logic     w_timeout;
  mem_cmd_t w_win_cmd;

  assign w_any_req = st_req | dma_req;
  assign w_grant   = (r_state == IDLE) && w_any_req;
  assign w_winner  = dma_req && (!st_req || w_dma_priority);
  assign w_timeout = (r_state == GRANT) && !mem_ack && (r_wait_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_win_cmd = pack_cmd(st_we, st_addr, st_wdata);
    if (w_winner == OWN_DMA) begin
      w_win_cmd = pack_cmd(dma_we, dma_addr, dma_wdata);
    end
  end

  mem_arb_fairness #(
    .MAX_DEFER(MAX_DEFER)
  ) u_fairness (
    .clock       (clock),
    .reset       (reset),
    .st_req      (st_req),
    .dma_req     (dma_req),
    .grant       (w_grant),
    .winner      (w_winner),
    .dma_priority(w_dma_priority)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_owner       <= OWN_ST;
      r_cmd         <= '0;
      r_wait_cnt    <= 8'd0;
      r_st_rdata    <= '0;
      r_dma_rdata   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= GRANT;
            r_owner    <= w_winner;
            r_cmd      <= w_win_cmd;
            r_wait_cnt <= 8'd0;
          end
        end
        GRANT: begin
          // Ack takes precedence over a timeout landing in the same cycle.
          if (mem_ack) begin
            if (r_owner == OWN_DMA) r_dma_rdata <= mem_rdata;
            else                    r_st_rdata  <= mem_rdata;
            r_state <= RESP;
          end else if (w_timeout) begin
            if (r_owner == OWN_DMA) r_dma_rdata <= '0;
            else                    r_st_rdata  <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= RESP;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_valid   = (r_state == GRANT);
  assign mem_we      = r_cmd.we;
  assign mem_addr    = r_cmd.addr;
  assign mem_wdata   = r_cmd.wdata;
  assign st_done     = (r_state == RESP) && (r_owner == OWN_ST);
  assign dma_done    = (r_state == RESP) && (r_owner == OWN_DMA);
  assign st_stall    = st_req & ~st_done;
  assign st_rdata    = r_st_rdata;
  assign dma_rdata   = r_dma_rdata;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grant
// order, port commands and responses; a port responder and a done monitor check them.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MAX_DEFER = 4;
  localparam int TIMEOUT   = 15;
  // tx record: {we, addr[16], wdata[12], rdata[12], ack_delay[8]}
  localparam int TX_W  = 49;
  localparam int CMD_W = 50;  // {owner, tx}
  localparam int RSP_W = 16;  // {owner, we, timed_out, timeout_err, rdata[12]}

  logic        clock = 1'b0;
  logic        reset;
  logic        st_req, st_we, dma_req, dma_we, mem_ack;
  logic [15:0] st_addr, dma_addr;
  logic [11:0] st_wdata, dma_wdata, mem_rdata;
  logic [11:0] st_rdata, dma_rdata, mem_wdata;
  logic        st_done, st_stall, dma_done, mem_valid, mem_we, timeout_err;
  logic [15:0] mem_addr;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  mem_port_arbiter #(.MAX_DEFER(MAX_DEFER), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .st_req(st_req), .st_we(st_we), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_rdata(st_rdata), .st_done(st_done), .st_stall(st_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [TX_W-1:0]  st_tx_q[$];
  logic [TX_W-1:0]  dma_tx_q[$];
  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [RSP_W-1:0] exp_q[$];

  logic model_terr = 1'b0;
  bit   resp_en    = 1'b1;
  bit   stray_ack  = 1'b0;
  bit   busy       = 1'b0;
  int   st_last_lat  = 0;
  int   done_cnt     = 0;
  int   first_dma_at = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [TX_W-1:0] make_tx(input logic we, input logic [15:0] addr,
      input logic [11:0] wdata, input logic [11:0] rdata, input logic [7:0] delay);
    return {we, addr, wdata, rdata, delay};
  endfunction

  // Reference model: replay arbitration over the two pending lists.
  task automatic build_expect();
    int i = 0;
    int j = 0;
    int defer = 0;
    bit take_dma;
    bit to;
    logic [TX_W-1:0] tx;
    while (i < st_tx_q.size() || j < dma_tx_q.size()) begin
      if (i < st_tx_q.size() && j < dma_tx_q.size()) begin
        if (defer == MAX_DEFER) begin take_dma = 1; defer = 0; end
        else begin take_dma = 0; defer = defer + 1; end
      end else begin
        take_dma = (j < dma_tx_q.size());
        defer = 0;
      end
      if (take_dma) begin tx = dma_tx_q[j]; j++; end
      else begin tx = st_tx_q[i]; i++; end
      to = (int'(tx[7:0]) >= TIMEOUT);
      if (to) model_terr = 1'b1;
      exp_cmd_q.push_back({take_dma, tx});
      exp_q.push_back({take_dma, tx[48], to, model_terr, to ? 12'h000 : tx[19:8]});
    end
  endtask

  task automatic drive_port(input bit is_dma);
    logic [TX_W-1:0] tx;
    int lat;
    bit first = 1;
    bit got;
    bit stall_ok;
    while ((is_dma ? dma_tx_q.size() : st_tx_q.size()) > 0) begin
      if (is_dma) begin
        tx = dma_tx_q.pop_front();
        dma_req = 1; dma_we = tx[48]; dma_addr = tx[47:32]; dma_wdata = tx[31:20];
      end else begin
        tx = st_tx_q.pop_front();
        st_req = 1; st_we = tx[48]; st_addr = tx[47:32]; st_wdata = tx[31:20];
        if (first) begin #1; check("st_stall_first", 32'(st_stall), 32'd1); end
      end
      first = 0;
      lat = 0; got = 0; stall_ok = 1;
      while (!got && lat < 400) begin
        @(negedge clock);
        lat++;
        if (is_dma ? dma_done : st_done) got = 1;
        else if (!is_dma && !st_stall) stall_ok = 0;
      end
      check(is_dma ? "dma_done_seen" : "st_done_seen", 32'(got), 32'd1);
      if (!is_dma) begin
        check("st_stall_while_pending", 32'(stall_ok), 32'd1);
        if (got) check("st_stall_at_done", 32'(st_stall), 32'd0);
        st_last_lat = lat;
      end
      if (!got) begin
        if (is_dma) dma_tx_q.delete(); else st_tx_q.delete();
      end
    end
    if (is_dma) dma_req = 0; else st_req = 0;
  endtask

  // Port responder: checks each granted command and acks after the planned delay.
  initial begin
    logic [CMD_W-1:0] cur;
    int k;
    int d;
    bit stable_ok;
    mem_ack = 0; mem_rdata = '0; cur = '0; k = 0; d = 0; stable_ok = 1;
    forever begin
      @(negedge clock);
      if (!resp_en) begin
        mem_ack = stray_ack; mem_rdata = 12'hFFF; busy = 0;
      end else begin
        if (!busy && mem_valid) begin
          if (exp_cmd_q.size() == 0) begin
            check("unexpected_grant", 32'(exp_cmd_q.size()), 32'd1);
            cur = '0;
          end else begin
            cur = exp_cmd_q.pop_front();
            check("grant_cmd", 32'({mem_we, mem_addr, mem_wdata}), 32'(cur[48:20]));
          end
          busy = 1; k = 0; d = int'(cur[7:0]); stable_ok = 1;
        end
        if (busy) begin
          if (mem_valid) begin
            if ({mem_we, mem_addr, mem_wdata} !== cur[48:20]) stable_ok = 0;
            mem_ack   = (k == d) || (k >= 100);
            mem_rdata = (k == d) ? cur[19:8] : 12'($urandom);
            k++;
          end else begin
            busy = 0; mem_ack = 0;
            check("grant_len", 32'(k), 32'((d < TIMEOUT) ? d + 1 : TIMEOUT));
            check("cmd_stable", 32'(stable_ok), 32'd1);
          end
        end else begin
          mem_ack = 0;
        end
      end
    end
  end

  // Done monitor: every done pulse pops one expected response.
  initial begin
    logic [RSP_W-1:0] r;
    forever begin
      @(negedge clock);
      if (st_done || dma_done) begin
        done_cnt++;
        if (dma_done && first_dma_at == 0) first_dma_at = done_cnt;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'({st_done, dma_done}), 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("done_owner", 32'({st_done, dma_done}), r[15] ? 32'd1 : 32'd2);
          check("timeout_err", 32'(timeout_err), 32'(r[12]));
          if (!r[14] || r[13])
            check("done_rdata", 32'(r[15] ? dma_rdata : st_rdata), 32'(r[11:0]));
        end
      end
    end
  end

  task automatic run_batch();
    int w = 0;
    build_expect();
    fork
      drive_port(1'b0);
      drive_port(1'b1);
    join
    while ((exp_q.size() > 0 || exp_cmd_q.size() > 0 || busy) && w < 50) begin
      @(negedge clock); w++;
    end
    check("batch_drained", 32'(exp_q.size() + exp_cmd_q.size()), 32'd0);
    exp_q.delete(); exp_cmd_q.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_done"}, 32'({st_done, dma_done}), 32'd0);
    check({tag, "_rdata"}, 32'({st_rdata, dma_rdata}), 32'd0);
    check({tag, "_cmd"}, 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_st_stall"}, 32'(st_stall), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  function automatic logic [7:0] rand_delay();
    int r = $urandom_range(0, 9);
    if (r < 7)  return 8'($urandom_range(0, 4));
    if (r == 7) return 8'(TIMEOUT - 1);
    if (r == 8) return 8'(TIMEOUT);
    return 8'd200;
  endfunction

  initial begin
    int w;
    reset = 1; st_req = 0; st_we = 0; st_addr = '0; st_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 0;
    @(negedge clock);

    // Ack exactly at the timeout threshold completes normally.
    st_tx_q.push_back(make_tx(1'b0, 16'h0100, 12'h000, 12'h7A5, 8'(TIMEOUT - 1)));
    run_batch();
    check("threshold_no_terr", 32'(timeout_err), 32'd0);

    // ST load alone.
    st_tx_q.push_back(make_tx(1'b0, 16'h1234, 12'h000, 12'hF85, 8'd3));
    run_batch();
    check("st_load_latency", 32'(st_last_lat), 32'd5);

    // DMA store alone.
    dma_tx_q.push_back(make_tx(1'b1, 16'h00FF, 12'h0AB, 12'h000, 8'd2));
    run_batch();

    // Both requesting continuously: DMA must get in by the fifth transaction.
    for (int i = 0; i < 6; i++) st_tx_q.push_back(make_tx(1'b0, 16'h2000 + 16'(i), 12'h0, 12'(i + 1), 8'd0));
    for (int i = 0; i < 2; i++) dma_tx_q.push_back(make_tx(1'b0, 16'h3000 + 16'(i), 12'h0, 12'(16 + i), 8'd1));
    done_cnt = 0; first_dma_at = 0;
    run_batch();
    check("dma_first_done_pos", 32'(first_dma_at), 32'd5);

    // No ack at all: timeout, rdata zero, sticky error.
    st_tx_q.push_back(make_tx(1'b0, 16'h4444, 12'h000, 12'h123, 8'd255));
    run_batch();
    check("terr_sticky", 32'(timeout_err), 32'd1);

    for (int b = 0; b < 12; b++) begin
      int ns = $urandom_range(0, 7);
      int nd = $urandom_range(0, 5);
      for (int i = 0; i < ns; i++)
        st_tx_q.push_back(make_tx(1'($urandom), 16'($urandom), 12'($urandom), 12'($urandom), rand_delay()));
      for (int i = 0; i < nd; i++)
        dma_tx_q.push_back(make_tx(1'($urandom), 16'($urandom), 12'($urandom), 12'($urandom), rand_delay()));
      run_batch();
    end

    // Reset in the middle of GRANT, followed by a stray ack in IDLE.
    resp_en = 0;
    @(negedge clock);
    st_req = 1; st_we = 1; st_addr = 16'h0AAA; st_wdata = 12'h555;
    w = 0;
    while (!mem_valid && w < 5) begin @(negedge clock); w++; end
    check("rst_test_grant", 32'(mem_valid), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1; st_req = 0;
    @(negedge clock);
    check_all_zero("mid_reset");
    reset = 0; model_terr = 0;
    stray_ack = 1;
    repeat (2) @(negedge clock);
    stray_ack = 0;
    repeat (3) @(negedge clock);
    check("stray_ack_state", 32'(dbg_state), 32'(IDLE));
    check("stray_ack_rdata", 32'({st_rdata, dma_rdata}), 32'd0);
    check("stray_ack_valid", 32'(mem_valid), 32'd0);
    check("stray_ack_terr", 32'(timeout_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
